// File: rtl/video_out_gen_pkg.sv
// Shared types and default raster geometry for the video output generator.
package video_pkg;

    localparam int unsigned P_WIDTH  = 640;
    localparam int unsigned P_HEIGHT = 480;
    localparam int unsigned P_LSYNC  = 160;
    localparam int unsigned P_FSYNC  = 40;

    typedef logic [7:0] pixel_t;

    // pixel_0 sits in the MSB byte and is the first pixel on the wire
    typedef struct packed {
        pixel_t pixel_0;
        pixel_t pixel_1;
        pixel_t pixel_2;
        pixel_t pixel_3;
    } pixel_quad_t;

    typedef union packed {
        logic [31:0] word;
        pixel_quad_t px;
    } pixel_pack_t;

    typedef enum logic [1:0] {
        IDLE,
        ACTIVE,
        LBLANK,
        FBLANK
    } vo_state_t;

    function automatic pixel_t pick_pixel(input pixel_pack_t w, input logic [1:0] sel);
        pixel_t p;
        case (sel)
            2'd0:    p = w.px.pixel_0;
            2'd1:    p = w.px.pixel_1;
            2'd2:    p = w.px.pixel_2;
            default: p = w.px.pixel_3;
        endcase
        return p;
    endfunction

endpackage

// File: rtl/video_out_gen_if.sv
// FIFO read side plus line_valid/frame_valid/pixel raster output of the video generator.
interface video_out_if;
    import video_pkg::*;

    logic        fifo_empty;
    logic [31:0] fifo_data;
    logic        r_e;
    pixel_t      pixel_out;
    logic        line_valid;
    logic        frame_valid;
    logic        underflow;

    modport master (
        input  fifo_empty, fifo_data,
        output r_e, pixel_out, line_valid, frame_valid, underflow
    );

    modport slave (
        output fifo_empty, fifo_data,
        input  r_e, pixel_out, line_valid, frame_valid, underflow
    );

endinterface

// File: rtl/video_out_gen_timing.sv
// Raster state machine for the video generator: produces state, column and line counters.
module video_out_timing
    import video_pkg::*;
#(
    parameter int unsigned P_WIDTH  = video_pkg::P_WIDTH,
    parameter int unsigned P_HEIGHT = video_pkg::P_HEIGHT,
    parameter int unsigned P_LSYNC  = video_pkg::P_LSYNC,
    parameter int unsigned P_FSYNC  = video_pkg::P_FSYNC
) (
    input  logic      clk,
    input  logic      nRST,
    input  logic      start_i,
    output vo_state_t state_o,
    output logic [9:0] col_o,
    output logic [9:0] line_o,
    output logic      frame_start_o
);

    localparam int unsigned FB_CLKS = P_FSYNC * (P_WIDTH + P_LSYNC);
    localparam int unsigned FB_W    = (FB_CLKS > 1) ? $clog2(FB_CLKS) : 1;

    vo_state_t       state_q, state_d;
    logic [9:0]      col_q, col_d;
    logic [9:0]      line_q, line_d;
    logic [FB_W-1:0] fb_q, fb_d;
    logic            frame_start;

    always_ff @(posedge clk or negedge nRST) begin
        if (!nRST) begin
            state_q <= IDLE;
            col_q   <= '0;
            line_q  <= '0;
            fb_q    <= '0;
        end else begin
            state_q <= state_d;
            col_q   <= col_d;
            line_q  <= line_d;
            fb_q    <= fb_d;
        end
    end

    // col doubles as the blanking counter during LBLANK
    always_comb begin
        state_d     = state_q;
        col_d       = col_q;
        line_d      = line_q;
        fb_d        = fb_q;
        frame_start = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (start_i) begin
                    state_d     = ACTIVE;
                    col_d       = '0;
                    line_d      = '0;
                    frame_start = 1'b1;
                end
            end
            ACTIVE: begin
                if (col_q == 10'(P_WIDTH - 1)) begin
                    state_d = LBLANK;
                    col_d   = '0;
                end else begin
                    col_d = col_q + 10'd1;
                end
            end
            LBLANK: begin
                if (col_q == 10'(P_LSYNC - 1)) begin
                    col_d = '0;
                    if (line_q < 10'(P_HEIGHT - 1)) begin
                        line_d  = line_q + 10'd1;
                        state_d = ACTIVE;
                    end else begin
                        fb_d    = '0;
                        state_d = FBLANK;
                    end
                end else begin
                    col_d = col_q + 10'd1;
                end
            end
            FBLANK: begin
                if (fb_q == FB_W'(FB_CLKS - 1)) begin
                    fb_d        = '0;
                    col_d       = '0;
                    line_d      = '0;
                    state_d     = ACTIVE;
                    frame_start = 1'b1;
                end else begin
                    fb_d = fb_q + 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    assign state_o       = state_q;
    assign col_o         = col_q;
    assign line_o        = line_q;
    assign frame_start_o = frame_start;

endmodule

// File: rtl/video_out_gen.sv
// Video output generator: pops FIFO words, unpacks 4 pixels each, drives raster timing.
// Optional feature macro: VIDEO_OUT_TEST_PATTERN_EN (adds test_mode input, col^line pattern).
module video_out_gen
    import video_pkg::*;
#(
    parameter int unsigned P_WIDTH  = video_pkg::P_WIDTH,
    parameter int unsigned P_HEIGHT = video_pkg::P_HEIGHT,
    parameter int unsigned P_LSYNC  = video_pkg::P_LSYNC,
    parameter int unsigned P_FSYNC  = video_pkg::P_FSYNC
) (
    input  logic clk,
    input  logic nRST,
`ifdef VIDEO_OUT_TEST_PATTERN_EN
    input  logic test_mode,
`endif
    video_out_if.master vo
);

    vo_state_t   state;
    logic [9:0]  col;
    logic [9:0]  line;
    logic        frame_start;
    logic        tm;
    logic        start;

    pixel_t      pixel_q, pixel_d;
    logic        lv_q, lv_d;
    logic        fv_q, fv_d;
    logic        uf_q, uf_d;
    pixel_pack_t word_q, word_d;
    logic        ok_q, ok_d;
    logic        re;

`ifdef VIDEO_OUT_TEST_PATTERN_EN
    logic tm_q;

    // test_mode only takes effect on a frame boundary
    always_ff @(posedge clk or negedge nRST) begin
        if (!nRST) begin
            tm_q <= 1'b0;
        end else if (frame_start) begin
            tm_q <= test_mode;
        end
    end

    assign tm    = tm_q;
    assign start = !vo.fifo_empty || test_mode;
`else
    assign tm    = 1'b0;
    assign start = !vo.fifo_empty;
`endif

    video_out_timing #(
        .P_WIDTH  (P_WIDTH),
        .P_HEIGHT (P_HEIGHT),
        .P_LSYNC  (P_LSYNC),
        .P_FSYNC  (P_FSYNC)
    ) u_timing (
        .clk           (clk),
        .nRST          (nRST),
        .start_i       (start),
        .state_o       (state),
        .col_o         (col),
        .line_o        (line),
        .frame_start_o (frame_start)
    );

    always_comb begin
        re      = 1'b0;
        pixel_d = '0;
        uf_d    = 1'b0;
        word_d  = word_q;
        ok_d    = ok_q;
        lv_d    = (state == ACTIVE);
        fv_d    = (state == ACTIVE) || (state == LBLANK);
        if (frame_start) begin
            ok_d = 1'b0;
        end
        if (state == ACTIVE) begin
            if (tm) begin
                pixel_d = pixel_t'(col ^ line);
            end else if (col[1:0] == 2'd0) begin
                // group head pixel bypasses the latch so the pop and the pixel share a cycle
                if (!vo.fifo_empty) begin
                    re      = 1'b1;
                    word_d  = vo.fifo_data;
                    ok_d    = 1'b1;
                    pixel_d = vo.fifo_data[31:24];
                end else begin
                    ok_d = 1'b0;
                    uf_d = 1'b1;
                end
            end else if (ok_q) begin
                pixel_d = pick_pixel(word_q, col[1:0]);
            end
        end
    end

    always_ff @(posedge clk or negedge nRST) begin
        if (!nRST) begin
            pixel_q <= '0;
            lv_q    <= 1'b0;
            fv_q    <= 1'b0;
            uf_q    <= 1'b0;
            word_q  <= '0;
            ok_q    <= 1'b0;
        end else begin
            pixel_q <= pixel_d;
            lv_q    <= lv_d;
            fv_q    <= fv_d;
            uf_q    <= uf_d;
            word_q  <= word_d;
            ok_q    <= ok_d;
        end
    end

    assign vo.r_e         = re;
    assign vo.pixel_out   = pixel_q;
    assign vo.line_valid  = lv_q;
    assign vo.frame_valid = fv_q;
    assign vo.underflow   = uf_q;

endmodule

// File: tb/tb_video_out_gen.sv
// Directed bench for video_out_gen on a reduced 8x4 raster (4 clk line blank, 2 line frame blank).
module tb_video_out_gen;
    import video_pkg::*;

    localparam int unsigned W     = 8;
    localparam int unsigned H     = 4;
    localparam int unsigned LS    = 4;
    localparam int unsigned FS    = 2;
    localparam int          LINE  = 12;
    localparam int          FRAME = 72;
    localparam int          UF_T  = 100;  // frame 1, line 2, col 4
    localparam int          RST_T = 161;  // frame 2, line 1, col 5

    logic clk = 1'b0;
    logic nRST;
`ifdef VIDEO_OUT_TEST_PATTERN_EN
    logic test_mode;
`endif

    video_out_if vo ();

    video_out_gen #(
        .P_WIDTH  (W),
        .P_HEIGHT (H),
        .P_LSYNC  (LS),
        .P_FSYNC  (FS)
    ) dut (
        .clk       (clk),
        .nRST      (nRST),
`ifdef VIDEO_OUT_TEST_PATTERN_EN
        .test_mode (test_mode),
`endif
        .vo        (vo)
    );

    always #5 clk = ~clk;

    int          checks   = 0;
    int          failures = 0;
    int          pops     = 0;
    int          np       = 0;
    logic [31:0] q[$];
    logic        pop;

    task automatic check_eq(input string tag, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, act, exp);
        end
    endtask

    function automatic logic [31:0] word_of(input int n);
        if (n == 0) return 32'h0A0B0C0D;
        if (n == 1) return 32'h01020304;
        return 32'h10203040 + 32'(n) * 32'h01010101;
    endfunction

    function automatic bit m_act(input int t);
        int f;
        if (t < 0) return 1'b0;
        f = t % FRAME;
        return (f < int'(H) * LINE) && ((f % LINE) < int'(W));
    endfunction

    function automatic bit m_fv(input int t);
        if (t < 0) return 1'b0;
        return (t % FRAME) < int'(H) * LINE;
    endfunction

    function automatic int m_col(input int t);
        return (t % FRAME) % LINE;
    endfunction

    task automatic refresh(input bit force_empty);
        vo.fifo_empty = force_empty || (q.size() == 0);
        vo.fifo_data  = (q.size() > 0) ? q[0] : '0;
    endtask

    task automatic tick(input bit force_empty);
        pop = vo.r_e;
        @(posedge clk);
        #1;
        if (pop && q.size() > 0) begin
            void'(q.pop_front());
            pops++;
            q.push_back(word_of(np));
            np++;
        end
        refresh(force_empty);
        #1;
    endtask

    initial begin
        int          ew;
        logic        grp_ok;
        logic [31:0] grp_w;
        int          c;
        logic [7:0]  exp_pix;
        logic        exp_uf;

        nRST = 1'b0;
`ifdef VIDEO_OUT_TEST_PATTERN_EN
        test_mode = 1'b0;
`endif
        for (int i = 0; i < 4; i++) begin
            q.push_back(word_of(np));
            np++;
        end
        refresh(1'b0);
        repeat (3) @(posedge clk);
        #1;
        check_eq("rst_pixel", vo.pixel_out, 0);
        check_eq("rst_lv", vo.line_valid, 0);
        check_eq("rst_fv", vo.frame_valid, 0);
        check_eq("rst_uf", vo.underflow, 0);
        check_eq("rst_re", vo.r_e, 0);

        nRST = 1'b1;
        #1;
        check_eq("idle_no_pop", vo.r_e, 0);

        ew = 0; grp_ok = 1'b0; grp_w = '0;
        for (int t = 0; t <= RST_T; t++) begin
            tick(t == UF_T);
            check_eq("re", vo.r_e, (m_act(t) && (m_col(t) % 4 == 0) && t != UF_T) ? 1 : 0);
            exp_pix = '0;
            exp_uf  = 1'b0;
            if (m_act(t - 1)) begin
                c = m_col(t - 1);
                if (c % 4 == 0) begin
                    if (t - 1 == UF_T) begin
                        grp_ok = 1'b0;
                        exp_uf = 1'b1;
                    end else begin
                        grp_ok = 1'b1;
                        grp_w  = word_of(ew);
                        ew++;
                    end
                end
                if (grp_ok) exp_pix = grp_w[31 - 8 * (c % 4) -: 8];
            end
            check_eq("lv", vo.line_valid, m_act(t - 1) ? 1 : 0);
            check_eq("fv", vo.frame_valid, m_fv(t - 1) ? 1 : 0);
            check_eq("pixel", vo.pixel_out, exp_pix);
            check_eq("uf", vo.underflow, exp_uf);
            if (t == 1) check_eq("first_px", vo.pixel_out, 8'h0A);
            if (t == 4) check_eq("px_col3", vo.pixel_out, 8'h0D);
            if (t == 5) check_eq("px_col4", vo.pixel_out, 8'h01);
            if (t == 8) check_eq("px_col7", vo.pixel_out, 8'h04);
            if (t == 72) check_eq("pops_frame0", pops, 8);
            if (t == 73) check_eq("frame1_start_lv", vo.line_valid, 1);
            if (t == 144) check_eq("pops_frame1_uf", pops, 15);
            if (t > UF_T + 1 && t <= UF_T + 4) check_eq("uf_group_zero", vo.pixel_out, 0);
        end

        #2;
        nRST = 1'b0;
        #1;
        check_eq("midrst_pixel", vo.pixel_out, 0);
        check_eq("midrst_lv", vo.line_valid, 0);
        check_eq("midrst_fv", vo.frame_valid, 0);
        check_eq("midrst_re", vo.r_e, 0);
        q.delete();
        refresh(1'b0);
        repeat (2) @(posedge clk);
        #1;
        nRST = 1'b1;
        for (int i = 0; i < 3; i++) begin
            tick(1'b0);
            check_eq("idle_lv", vo.line_valid, 0);
            check_eq("idle_fv", vo.frame_valid, 0);
            check_eq("idle_re", vo.r_e, 0);
        end
        q.push_back(32'hA1B2C3D4);
        q.push_back(32'h55667788);
        refresh(1'b0);
        #1;
        check_eq("restart_idle_re", vo.r_e, 0);
        tick(1'b0);
        check_eq("restart_re_col0", vo.r_e, 1);
        tick(1'b0);
        check_eq("restart_px0", vo.pixel_out, 8'hA1);
        check_eq("restart_lv", vo.line_valid, 1);
        tick(1'b0);
        check_eq("restart_px1", vo.pixel_out, 8'hB2);
        tick(1'b0);
        check_eq("restart_px2", vo.pixel_out, 8'hC3);
        tick(1'b0);
        check_eq("restart_re_col4", vo.r_e, 1);
        check_eq("restart_px3", vo.pixel_out, 8'hD4);
        tick(1'b0);
        check_eq("restart_px4", vo.pixel_out, 8'h55);

`ifdef VIDEO_OUT_TEST_PATTERN_EN
        nRST = 1'b0;
        test_mode = 1'b1;
        q.delete();
        refresh(1'b0);
        @(posedge clk);
        #1;
        nRST = 1'b1;
        for (int t = 0; t <= 30; t++) begin
            tick(1'b0);
            check_eq("tp_re", vo.r_e, 0);
            check_eq("tp_uf", vo.underflow, 0);
            if (t == 30) check_eq("tp_px_l2c5", vo.pixel_out, 8'h07);
        end
`endif

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
